// File: rtl/adc_avg_pkg.sv
// Shared types and constants for the ADC averaging front end.
package adc_avg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACCUM  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Headroom bits above the raw sample width, enough for 2^15 summed samples.
  localparam int ACC_EXTRA = 15;

  // Left shift that places the ADC MSB weight at -1.0 in the Q result.
  function automatic int frac_shift(input int fp_width, input int int_width, input int adc_bits);
    return (fp_width - int_width) - (adc_bits - 1);
  endfunction

endpackage

// File: rtl/adc_fix_conv.sv
// Accumulator to signed Q(INT).(FRAC) conversion: scale up, divide by 2^avg_log2.
// Purely combinational; no handshake, the caller registers the result.
module adc_fix_conv
  import adc_avg_pkg::*;
#(
  parameter int FP_WIDTH  = 32,
  parameter int INT_WIDTH = 16,
  parameter int ADC_BITS  = 14,
  parameter int ACC_W     = ADC_BITS + ACC_EXTRA
) (
  input  logic signed [ACC_W-1:0]    acc,
  input  logic        [3:0]          avg_log2,
  output logic        [FP_WIDTH-1:0] q
);

  localparam int SH = frac_shift(FP_WIDTH, INT_WIDTH, ADC_BITS);
  // Working width holds the scaled accumulator and is never narrower than the result.
  localparam int CW = (ACC_W + SH > FP_WIDTH) ? (ACC_W + SH) : FP_WIDTH;

  logic signed [CW-1:0] wide;
  logic signed [CW-1:0] shifted;

  always_comb begin
    wide    = CW'(acc);
    shifted = (wide <<< SH) >>> avg_log2;
    q       = shifted[FP_WIDTH-1:0];
  end

endmodule

// File: rtl/adc_avg_frontend.sv
// Settle-then-average ADC acquisition; result registered on the edge of the last sample.
// No backpressure: samples outside ACCUM are dropped, ADC_DONE is a level held until ADC_EN falls.
module adc_avg_frontend
  import adc_avg_pkg::*;
#(
  parameter int FP_WIDTH     = 32,
  parameter int INT_WIDTH    = 16,
  parameter int ADC_BITS     = 14,
  parameter int SETTLE_WIDTH = 16
) (
  input  logic                    ADC_CLK,
  input  logic                    REG_RST,
  input  logic                    ADC_EN,
  input  logic [ADC_BITS-1:0]     SAMPLE_IN,
  input  logic                    SAMPLE_VALID,
  input  logic [3:0]              AVG_LOG2,
  input  logic [SETTLE_WIDTH-1:0] SETTLE,
  output logic [FP_WIDTH-1:0]     ADC_IN,
  output logic                    ADC_DONE,
  output logic                    OVR,
  output logic [1:0]              STATE
);

  localparam int ACC_W = ADC_BITS + ACC_EXTRA;
  localparam logic [ADC_BITS-1:0] CODE_MAX = {1'b0, {(ADC_BITS-1){1'b1}}};
  localparam logic [ADC_BITS-1:0] CODE_MIN = {1'b1, {(ADC_BITS-1){1'b0}}};

  state_t                   state;
  logic [SETTLE_WIDTH-1:0]  settle_cnt;
  logic [3:0]               avg_q;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nxt;
  logic [15:0]              smp_cnt;
  logic                     ovr_acc;
  logic                     full_scale;
  logic                     last_smp;
  logic [FP_WIDTH-1:0]      q_nxt;

  always_comb begin
    acc_nxt    = acc + ACC_W'(signed'(SAMPLE_IN));
    full_scale = (SAMPLE_IN == CODE_MAX) || (SAMPLE_IN == CODE_MIN);
    last_smp   = (smp_cnt + 16'd1) == (16'd1 << avg_q);
  end

  // Converts the post-add sum so the result lands on the same edge as the final sample.
  adc_fix_conv #(
    .FP_WIDTH (FP_WIDTH),
    .INT_WIDTH(INT_WIDTH),
    .ADC_BITS (ADC_BITS),
    .ACC_W    (ACC_W)
  ) u_conv (
    .acc     (acc_nxt),
    .avg_log2(avg_q),
    .q       (q_nxt)
  );

  always_ff @(posedge ADC_CLK) begin
    if (REG_RST) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      avg_q      <= '0;
      acc        <= '0;
      smp_cnt    <= '0;
      ovr_acc    <= 1'b0;
      ADC_IN     <= '0;
      ADC_DONE   <= 1'b0;
      OVR        <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ADC_EN) begin
            avg_q      <= AVG_LOG2;
            settle_cnt <= SETTLE;
            acc        <= '0;
            smp_cnt    <= '0;
            ovr_acc    <= 1'b0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!ADC_EN) begin
            state <= ST_IDLE;
          end else if (settle_cnt == '0) begin
            state <= ST_ACCUM;
          end else begin
            settle_cnt <= settle_cnt - 1'b1;
          end
        end
        ST_ACCUM: begin
          // An abort wins over a completing sample; published outputs stay untouched.
          if (!ADC_EN) begin
            state <= ST_IDLE;
          end else if (SAMPLE_VALID) begin
            acc     <= acc_nxt;
            smp_cnt <= smp_cnt + 16'd1;
            ovr_acc <= ovr_acc | full_scale;
            if (last_smp) begin
              ADC_IN   <= q_nxt;
              OVR      <= ovr_acc | full_scale;
              ADC_DONE <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (!ADC_EN) begin
            ADC_DONE <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign STATE = state;

endmodule
